// File: rtl/tag_rx_symb_accum_if.sv
// Sample-in / symbol-out stream bundle for tag_rx_symb_accum.
// master = upstream source and downstream sink; slave = the accumulator.
interface tag_rx_symb_accum_if #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned NSYMB_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]   irx_in;
   logic [DATA_WIDTH-1:0]   qrx_in;
   logic                    in_tvalid;
   logic [NSYMB_WIDTH-1:0]  symbN;
   logic [2*DATA_WIDTH-1:0] out_tdata;
   logic [NSYMB_WIDTH-1:0]  out_tuser;
   logic                    out_tvalid;
   logic                    out_tlast;
   logic                    out_tready;

   modport master (
      output irx_in, qrx_in, in_tvalid, symbN, out_tready,
      input  out_tdata, out_tuser, out_tvalid, out_tlast
   );

   modport slave (
      input  irx_in, qrx_in, in_tvalid, symbN, out_tready,
      output out_tdata, out_tuser, out_tvalid, out_tlast
   );
endinterface

// File: rtl/tag_rx_symb_accum.sv
// Per-symbol I/Q accumulator with output FIFO for the tag receiver.
// Define TAG_RX_ACCUM_SAT_EN to clamp scaled sums instead of wrapping them.
module tag_rx_symb_accum #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned NSYMB_WIDTH = 16,
   parameter int unsigned NSYMB       = 64,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter int unsigned OUT_SHIFT   = 16,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_rx,
   input  logic                 rx_trig,
   tag_rx_symb_accum_if.slave   bus,
   output logic                 overflow,
   output logic [1:0]           acc_state
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = 2 * DATA_WIDTH + NSYMB_WIDTH + 1;
   localparam logic [NSYMB_WIDTH-1:0] LastSymb = NSYMB_WIDTH'(NSYMB - 1);
`ifdef TAG_RX_ACCUM_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArm   = 2'b01,
      StAccum = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e                        state_q, state_d;
   logic signed [ACC_WIDTH-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [NSYMB_WIDTH-1:0]        cur_symb_q, cur_symb_d;
   logic                          loaded_q, loaded_d;
   logic                          push, push_last;
   logic signed [ACC_WIDTH-1:0]   samp_i, samp_q;

   function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [ACC_WIDTH-1:0] acc);
      logic signed [ACC_WIDTH-1:0] sh;
      sh = acc >>> OUT_SHIFT;
`ifdef TAG_RX_ACCUM_SAT_EN
      if (sh > SatMax) return DATA_WIDTH'(SatMax);
      if (sh < SatMin) return DATA_WIDTH'(SatMin);
`endif
      return DATA_WIDTH'(sh);
   endfunction

   assign samp_i = {{(ACC_WIDTH-DATA_WIDTH){bus.irx_in[DATA_WIDTH-1]}}, bus.irx_in};
   assign samp_q = {{(ACC_WIDTH-DATA_WIDTH){bus.qrx_in[DATA_WIDTH-1]}}, bus.qrx_in};
   assign acc_state = state_q;

   always_comb begin
      state_d    = state_q;
      acc_i_d    = acc_i_q;
      acc_q_d    = acc_q_q;
      cur_symb_d = cur_symb_q;
      loaded_d   = loaded_q;
      push       = 1'b0;
      push_last  = 1'b0;
      case (state_q)
         StIdle: if (rx_trig) state_d = StArm;
         StArm: begin
            loaded_d = 1'b0;
            if (!rx_trig) state_d = StAccum;
         end
         StAccum: begin
            if (rx_trig) begin
               // Re-sync: drop the partial symbol and wait for the next falling edge
               state_d  = StArm;
               loaded_d = 1'b0;
            end else if (bus.in_tvalid) begin
               if (loaded_q && bus.symbN == cur_symb_q) begin
                  acc_i_d = acc_i_q + samp_i;
                  acc_q_d = acc_q_q + samp_q;
               end else begin
                  push = loaded_q;
                  if (loaded_q && cur_symb_q == LastSymb) begin
                     push_last = 1'b1;
                     loaded_d  = 1'b0;
                     state_d   = StDone;
                  end else begin
                     acc_i_d    = samp_i;
                     acc_q_d    = samp_q;
                     cur_symb_d = bus.symbN;
                     loaded_d   = 1'b1;
                  end
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         acc_i_q    <= '0;
         acc_q_q    <= '0;
         cur_symb_q <= '0;
         loaded_q   <= 1'b0;
      end else if (!run_rx) begin
         state_q    <= StIdle;
         acc_i_q    <= '0;
         acc_q_q    <= '0;
         cur_symb_q <= '0;
         loaded_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_i_q    <= acc_i_d;
         acc_q_q    <= acc_q_d;
         cur_symb_q <= cur_symb_d;
         loaded_q   <= loaded_d;
      end
   end

   // Output FIFO: registered head, so a push is visible one cycle later at the earliest
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] push_entry, head;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full, empty, pop, push_ok;

   assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty      = (count_q == '0);
   assign pop        = !empty && bus.out_tready;
   assign push_ok    = run_rx && push && (!full || pop);
   assign push_entry = {scale(acc_i_q), scale(acc_q_q), cur_symb_q, push_last};
   assign head       = empty ? '0 : mem_q[rd_ptr_q];

   assign bus.out_tvalid = !empty;
   assign {bus.out_tdata, bus.out_tuser, bus.out_tlast} = head;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else if (!run_rx) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         if (push && full && !pop) overflow <= 1'b1;
      end
   end
endmodule
